// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data memory for the MEM stage.
// Accepts a load or store in IDLE, stalls the pipeline for LATENCY busy
// cycles, then pulses ready_o (and err_o for rejected accesses) for one cycle.
module dmem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int LATENCY     = 2,
    parameter int CNT_W       = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Memory_read_i,
    input  logic        Memory_write_i,
    input  logic [31:0] address_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS * 4);
    localparam int IDX_W  = ADDR_W - 2;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [31:0]      data;
    logic             is_write;
    logic             is_bad;
    logic             request;
    logic             reject;
    logic             finish;

    logic [31:0] mem [DEPTH_WORDS];

    // Request decode, rejection rules and the combinational pipeline stall.
    always_comb begin
        request = Memory_read_i | Memory_write_i;
        reject  = (address_i[1:0] != 2'b00)
               || (address_i >= 32'(DEPTH_WORDS * 4))
               || (Memory_read_i && Memory_write_i);
        finish  = (state == BUSY) && (cnt == '0);
        stall_o = ((state == IDLE) && request) || (state == BUSY);
    end

    // Control FSM: latch the access, count down the latency, report completion.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            data        <= '0;
            is_write    <= 1'b0;
            is_bad      <= 1'b0;
            read_data_o <= '0;
            ready_o     <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            ready_o <= finish;
            err_o   <= finish & is_bad;
            case (state)
                IDLE: begin
                    if (request) begin
                        idx      <= address_i[ADDR_W-1:2];
                        data     <= write_data_i;
                        is_write <= Memory_write_i;
                        is_bad   <= reject;
                        cnt      <= CNT_W'(LATENCY - 1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_W'(1);
                    end else begin
                        state <= DONE;
                        if (is_bad) begin
                            read_data_o <= '0;
                        end else if (!is_write) begin
                            read_data_o <= mem[idx];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage write on the completing edge; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && finish && is_write && !is_bad) begin
            mem[idx] <= data;
        end
    end

endmodule
